// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse generator.
// State encodings and cycle-counter width.
package pulse_gen_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } state_t;

    function automatic logic is_active(input state_t s);
        return (s == HIGH) || (s == LOW);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter used to queue pending triggers.
// Simultaneous inc and dec leave the value unchanged.
module sat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             saturated
);

    localparam logic [WIDTH-1:0] MAX = '1;

    assign saturated = (value == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !dec && !saturated) begin
            value <= value + 1'b1;
        end else if (dec && !inc && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

endmodule

// File: rtl/pulse_gen.sv
// Fixed-width pulse generator with queued triggers.
// Three-state FSM plus a shared high/low cycle counter.
module pulse_gen #(
    parameter int unsigned HIGH_CYC = 2,
    parameter int unsigned LOW_CYC  = 1,
    parameter int unsigned PEND_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              clr,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    import pulse_gen_pkg::*;

    localparam logic [CNT_W-1:0] HI_LD = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LO_LD = CNT_W'(LOW_CYC - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             inc;
    logic             dec;
    logic             sat;
    logic             pend_nz;

    assign pend_nz = (pending != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        inc      = 1'b0;
        dec      = 1'b0;
        if (clr) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                HIGH: begin
                    inc = trig;
                    if (cnt == '0) begin
                        state_nx = LOW;
                        cnt_nx   = LO_LD;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                LOW: begin
                    if (cnt != '0) begin
                        inc    = trig;
                        cnt_nx = cnt - 1'b1;
                    end else if (pend_nz) begin
                        // consume one queued trigger; a new trig refills it
                        dec      = 1'b1;
                        inc      = trig;
                        state_nx = HIGH;
                        cnt_nx   = HI_LD;
                    end else if (trig) begin
                        state_nx = HIGH;
                        cnt_nx   = HI_LD;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    // covers IDLE and the unused 2'b11 encoding
                    if (trig) begin
                        state_nx = HIGH;
                        cnt_nx   = HI_LD;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (inc && !dec && sat) begin
            ovf <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH(PEND_W)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc),
        .dec      (dec),
        .clr      (clr),
        .value    (pending),
        .saturated(sat)
    );

    assign out  = (state == HIGH);
    assign busy = is_active(state);

endmodule

// File: tb/tb_pulse_gen.sv
// Directed-vector bench for pulse_gen.
// Two instances: defaults, and PEND_W=2 with a long pulse.
module tb_pulse_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic       clr = 1'b0;
    logic       trig2 = 1'b0;
    logic       clr2 = 1'b0;
    logic       out;
    logic       busy;
    logic [3:0] pending;
    logic       ovf;
    logic       out2;
    logic       busy2;
    logic [1:0] pending2;
    logic       ovf2;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pulse_gen u_dut (
        .clk    (clk),
        .rst    (rst),
        .trig   (trig),
        .clr    (clr),
        .out    (out),
        .busy   (busy),
        .pending(pending),
        .ovf    (ovf)
    );

    pulse_gen #(
        .HIGH_CYC(5),
        .LOW_CYC (1),
        .PEND_W  (2)
    ) u_dut2 (
        .clk    (clk),
        .rst    (rst),
        .trig   (trig2),
        .clr    (clr2),
        .out    (out2),
        .busy   (busy2),
        .pending(pending2),
        .ovf    (ovf2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input logic t, input logic c,
                        input logic t2, input logic c2);
        trig  = t;
        clr   = c;
        trig2 = t2;
        clr2  = c2;
        @(posedge clk);
        #1;
        trig  = 1'b0;
        clr   = 1'b0;
        trig2 = 1'b0;
        clr2  = 1'b0;
    endtask

    // tv: trig per tick; eo/eb/ep: expected out/busy/pending after each tick
    task automatic seq(input string tag, input logic [15:0] tv,
                       input int n, input logic [15:0] eo,
                       input logic [15:0] eb, input logic [63:0] ep);
        for (int i = 0; i < n; i++) begin
            tick(tv[i], 1'b0, 1'b0, 1'b0);
            check($sformatf("%s.out[%0d]", tag, i), int'(out), int'(eo[i]));
            check($sformatf("%s.busy[%0d]", tag, i), int'(busy), int'(eb[i]));
            check($sformatf("%s.pend[%0d]", tag, i), int'(pending),
                  int'(ep[4*i +: 4]));
        end
        check({tag, ".ovf"}, int'(ovf), 0);
    endtask

    initial begin
        int pulses;
        logic prev;

        @(posedge clk);
        #3;
        check("rst.out", int'(out), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.pend", int'(pending), 0);
        check("rst.ovf", int'(ovf), 0);
        check("rst.out2", int'(out2), 0);
        rst = 1'b0;
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);

        seq("single", 16'h0001, 5, 16'h0003, 16'h0007, 64'h0);
        seq("burst3", 16'h0007, 10, 16'h00DB, 16'h01FF, 64'h0000111210);
        seq("lowexit", 16'h000B, 10, 16'h00DB, 16'h01FF, 64'h0000111110);

        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("clr.pre_out", int'(out), 1);
        check("clr.pre_pend", int'(pending), 1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("clr.out", int'(out), 0);
        check("clr.busy", int'(busy), 0);
        check("clr.pend", int'(pending), 0);
        check("clr.ovf", int'(ovf), 0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("clr.quiet[%0d]", i), int'(out), 0);
        end

        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("arst.pre_out", int'(out), 1);
        #2 rst = 1'b1;
        #1;
        check("arst.out", int'(out), 0);
        check("arst.busy", int'(busy), 0);
        check("arst.pend", int'(pending), 0);
        #1 rst = 1'b0;
        seq("post_rst", 16'h0001, 4, 16'h0003, 16'h0007, 64'h0);

        pulses = 0;
        prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0, (i < 6), 1'b0);
            if (out2 && !prev) pulses++;
            prev = out2;
            if (i == 3) begin
                check("sat.pend4", int'(pending2), 3);
                check("sat.ovf4", int'(ovf2), 0);
            end
            if (i == 4) check("sat.ovf5", int'(ovf2), 1);
            if (i == 5) check("sat.pend6", int'(pending2), 3);
        end
        check("sat.pulses", pulses, 4);
        check("sat.pend_end", int'(pending2), 0);
        check("sat.busy_end", int'(busy2), 0);
        check("sat.ovf_sticky", int'(ovf2), 1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat.ovf_clr", int'(ovf2), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 Parameter HIGH_CYC, default 2, number of cycles each output pulse is high (legal range 1..255).
REQ-002 Parameter LOW_CYC, default 1, minimum low cycles between back-to-back output pulses (legal range 1..255).
REQ-003 Parameter PEND_W, default 4, width of the pending-trigger counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 trig  input  1  single-cycle pulse request, sampled each rising edge.
REQ-007 clr  input  1  synchronous clear of all state.
REQ-008 out  output  1  registered output pulse.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 pending  output  PEND_W  count of accepted triggers not yet started.
REQ-011 ovf  output  1  sticky flag, trigger lost to a saturated pending counter.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, HIGH, LOW.
REQ-013 out SHALL be 1 exactly when the state is HIGH, decoded from the state register with no combinational path from trig.
REQ-014 IDLE with trig=1 SHALL go to HIGH next cycle with the cycle counter loaded to HIGH_CYC-1, so out rises one cycle after trig.
REQ-015 IDLE with trig=0 SHALL stay in IDLE.
REQ-016 HIGH SHALL decrement the counter each cycle and, when the counter is 0, go to LOW with the counter loaded to LOW_CYC-1, so out is high for exactly HIGH_CYC cycles.
REQ-017 LOW SHALL decrement the counter each cycle and, when the counter is 0, go to HIGH if pending>0 or trig=1, otherwise to IDLE.
REQ-018 A trig received while in HIGH or LOW, other than at the LOW-exit cycle with pending=0, SHALL increment pending.
REQ-019 At the LOW exit cycle with pending>0, one pending trigger SHALL be consumed (pending decremented).
REQ-020 At the LOW exit cycle with pending>0 and trig=1, pending SHALL stay unchanged (consume plus accept).
REQ-021 At the LOW exit cycle with pending=0 and trig=1, the trig SHALL start the next pulse directly and pending SHALL stay 0.
REQ-022 pending SHALL saturate at 2^PEND_W-1.
REQ-023 A trig that would increment pending while it is saturated SHALL be dropped and SHALL set ovf.
REQ-024 ovf SHALL remain set until clr or rst.
REQ-025 pending SHALL never wrap.
REQ-026 clr=1 SHALL force IDLE, counter 0, pending 0 and ovf 0 on the next edge, and a trig in the same cycle SHALL be ignored.
REQ-027 clr SHALL take priority over every other input.
REQ-028 A clr applied mid-pulse SHALL drop out to 0 on the next cycle with no shortened-pulse recovery.
REQ-029 With HIGH_CYC=2, an isolated trig SHALL produce a 2-cycle high pulse.

Reset
REQ-030 rst=1 SHALL asynchronously force state IDLE, counter 0, pending 0, ovf 0, out 0 and busy 0, independent of clk.
REQ-031 Reset asserted mid-pulse SHALL drop out immediately.
REQ-032 After rst deasserts, the first trig SHALL behave as in REQ-014.

Structure
REQ-033 State encodings (IDLE=2'b00, HIGH=2'b01, LOW=2'b10) SHALL be defined as named constants in the shared package pulse_gen_pkg.
REQ-034 Encoding 2'b11 SHALL be treated as IDLE.
REQ-035 The pending counter SHALL be a sub-module sat_counter (parameter width; inputs inc, dec, clr; outputs value, saturated).
REQ-036 The FSM and cycle counter SHALL reside in pulse_gen.

Verification
REQ-037 Defaults, single trig at cycle 10 -> out=1 in cycles 11-12, 0 at cycle 13, busy 11-13, then IDLE at 14.
REQ-038 Defaults, trigs at cycles 10, 11, 12 -> pending peaks at 2; pulses in cycles 11-12, 14-15, 17-18; pending back to 0; ovf=0.
REQ-039 PEND_W=2, 6 consecutive trigs -> pending saturates at 3, ovf=1 after the 5th trig, exactly 4 pulses emitted.
REQ-040 Trig exactly on the LOW exit cycle with pending=1 -> pending stays 1 and the next pulse starts immediately.
REQ-041 clr asserted during HIGH together with trig -> next cycle out=0, busy=0, pending=0, ovf=0, with no later pulse.
REQ-042 rst pulsed asynchronously mid-HIGH between clock edges -> out falls without waiting for clk; the next trig yields a normal 2-cycle pulse.
